// File: rtl/image_loader_pkg.sv
// image_loader_pkg: shared image geometry constants (pixel width, per-bank address width, frame dimensions)
package image_loader_pkg;
  localparam int PIX_WD = 16;
  localparam int ADDR_W = 10;
  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;
endpackage

// File: rtl/image_buf_2bank.sv
// image_buf_2bank: two-bank pixel store; one write port, one registered read port (bank select is the address MSB)
module image_buf_2bank #(
  parameter int WD = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [WD-1:0] wdata,
  input  logic          re,
  input  logic [AW:0]   raddr,
  output logic [WD-1:0] rdata
);
  logic [WD-1:0] mem [2**(AW+1)];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/image_loader.sv
// image_loader: ping-pong frame loader feeding a lenet core; ports: pixel stream in (valid/ready/data/last), go/lenet_ready/digit core handshake, core read port (aa_image/cena_image/conv1_image), result/result_valid, sticky err_len
module image_loader
  import image_loader_pkg::*;
#(
  parameter int WD = PIX_WD,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic [WD-1:0] pix_data,
  input  logic          pix_last,
  output logic          go,
  input  logic          lenet_ready,
  input  logic [AW-1:0] aa_image,
  input  logic          cena_image,
  output logic [WD-1:0] conv1_image,
  input  logic [3:0]    digit,
  output logic [3:0]    result,
  output logic          result_valid,
  output logic          err_len
);
  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;
  state_t state, state_nx;
  logic wb, rb, lr_q, xfer, at_end, frame_ok;
  logic [1:0] full, full_nx;
  logic [AW-1:0] wa;
  assign pix_ready = ~full[wb];
  assign xfer = pix_valid & pix_ready;
  assign at_end = &wa;
  assign frame_ok = xfer & pix_last & at_end;
  assign go = state == START;
  assign result_valid = state == DONE;
  // DONE frees the read bank while a completing frame may fill the write bank; they are always different banks
  always_comb begin
    full_nx = full;
    if (state == DONE) full_nx[rb] = 1'b0;
    if (frame_ok) full_nx[wb] = 1'b1;
  end
  // lr_q makes RUN react only to a fresh rising edge, not a level already high on entry
  always_comb begin
    state_nx = (state == IDLE && full[rb]) ? START :
               (state == START) ? RUN :
               (state == RUN && lenet_ready && !lr_q) ? DONE :
               (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wb      <= 1'b0;
      rb      <= 1'b0;
      full    <= 2'b00;
      wa      <= '0;
      lr_q    <= 1'b0;
      result  <= 4'd0;
      err_len <= 1'b0;
    end else begin
      state <= state_nx;
      full  <= full_nx;
      lr_q  <= lenet_ready;
      if (state == RUN && state_nx == DONE) result <= digit;
      if (state == DONE) rb <= ~rb;
      // a last/final-index disagreement discards the frame: wa restarts and the bank stays empty
      if (xfer) begin
        wa      <= (pix_last | at_end) ? '0 : wa + 1'b1;
        wb      <= wb ^ frame_ok;
        err_len <= err_len | (pix_last ^ at_end);
      end
    end
  end
  image_buf_2bank #(.WD(WD), .AW(AW)) u_buf (
    .clk(clk), .rst(rst),
    .we(xfer), .waddr({wb, wa}), .wdata(pix_data),
    .re(~cena_image), .raddr({rb, aa_image}), .rdata(conv1_image)
  );
endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter WD, default `WD from global.v, meaning the pixel and word width.
REQ-002 SHALL have parameter AW, default 10, meaning the per-bank address width (1024 pixels, 32x32).
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- pix_valid  in  1  upstream pixel valid.
- pix_ready  out  1  loader can accept a pixel.
- pix_data  in  WD  pixel, raster order.
- pix_last  in  1  marks the final pixel of a frame.
- go  out  1  one-cycle start pulse to the lenet core.
- lenet_ready  in  1  core ready/done level.
- aa_image  in  AW  core read address.
- cena_image  in  1  core read enable, active low.
- conv1_image  out  WD  read data to the core.
- digit  in  4  core classification result.
- result  out  4  latched digit.
- result_valid  out  1  one-cycle pulse when result updates.
- err_len  out  1  sticky frame-length error.

Function
REQ-005 SHALL hold two banks of 2^AW x WD storage (ping-pong), with write bank pointer wb, read bank pointer rb and per-bank full flags full[1:0].
REQ-006 SHALL drive pix_ready = ~full[wb]; a transfer occurs on pix_valid & pix_ready.
REQ-007 SHALL write each transferred pixel to mem[{wb,wa}], then increment write counter wa.
REQ-008 SHALL, on a transfer with wa == 2^AW-1 and pix_last = 1, set full[wb], toggle wb and clear wa in the same edge.
REQ-009 SHALL, on a transfer where pix_last does not coincide with wa == 2^AW-1 (early last, or missing last at final index), set err_len, clear wa and leave full[wb] = 0 (frame discarded).
REQ-010 SHALL keep err_len set until reset.
REQ-011 SHALL implement run FSM states IDLE, START, RUN and DONE.
REQ-012 IDLE -> START when full[rb] = 1.
REQ-013 START SHALL assert go for exactly one cycle, then go to RUN.
REQ-014 RUN SHALL detect a rising edge of lenet_ready (registered previous value); it SHALL ignore a level already high on RUN entry.
REQ-015 On that edge the FSM SHALL go to DONE, capturing digit into result.
REQ-016 DONE SHALL pulse result_valid for one cycle, clear full[rb], toggle rb and return to IDLE.
REQ-017 SHALL register the read port: when cena_image = 0, conv1_image <= mem[{rb,aa_image}] (1-cycle latency); when cena_image = 1, conv1_image holds.
REQ-018 SHALL allow loading into bank wb concurrently with core reads of bank rb; the writer never targets a full bank.
REQ-019 SHALL apply both updates when DONE clears full[rb] and a frame completion sets full[wb] in the same cycle.
REQ-020 SHALL, with both banks full, hold pix_ready = 0 until DONE frees a bank, with pix_ready rising the cycle after.
REQ-021 SHALL ignore the values of pix_data and pix_last when no transfer occurs.

Reset
REQ-022 On rst SHALL set wb = rb = 0, full = 00, wa = 0, FSM = IDLE, and go, result_valid, err_len = 0, result = 0 and conv1_image = 0; memory contents are unaffected.
REQ-023 Reset mid-frame or mid-RUN SHALL discard all frames; pix_ready = 1 the first cycle after release.

Structure
REQ-024 WD, AW and the image dimension constants SHALL reside in global.v; FSM state encodings SHALL be local.
REQ-025 Storage SHALL be one sub-module, image_buf_2bank (one write port, one registered read port).

Verification
REQ-026 Stream 1024 pixels with pix_data = index and pix_last on index 1023 -> one go pulse two cycles after the final transfer; a read at address 5 with cena_image = 0 returns 5 the next cycle.
REQ-027 In RUN, raise lenet_ready with digit = 7 -> result = 7 and a one-cycle result_valid pulse, after which full[0] clears and rb = 1.
REQ-028 Stream frame B while frame A runs, then stream frame C -> pix_ready drops after B completes and rises one cycle after A's DONE; frame B's go follows.
REQ-029 Assert pix_last at index 500 -> err_len = 1 and no go; the next correct frame loads into the same bank and starts normally.
REQ-030 Assert rst at pixel 600 and again during RUN -> all outputs = 0 and pix_ready = 1 after release; no stale go appears.
REQ-031 Hold lenet_ready = 1 on RUN entry -> no capture until it falls and rises again.
